alu_flag_retire: RTL and testbench

Downstream consumer of the 32-bit ALU. Accepts one ALU result per handshake with its condition code and set-flags bit, keeps the architectural NZCV status register, and evaluates the ARM condition against the current flags. It queues retired results in a 2-entry buffer for register-file writeback and feeds the stored carry back to the ALU `Ci` input.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/cond_eval.sv | 39 +++
 rtl/alu_flag_retire.sv | 104 ++++++++++
 tb/tb_alu_flag_retire.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, ARM condition codes, NZCV bit positions
// and the retire buffer entry layout.
package alu_pkg;

    localparam logic [0:3] OP_ADD = 4'b0111;
    localparam logic [0:3] OP_SUB = 4'b1000;
    localparam logic [0:3] OP_ADC = 4'b1001;
    localparam logic [0:3] OP_SBC = 4'b1010;

    localparam logic [0:3] COND_EQ = 4'b0000;
    localparam logic [0:3] COND_NE = 4'b0001;
    localparam logic [0:3] COND_CS = 4'b0010;
    localparam logic [0:3] COND_CC = 4'b0011;
    localparam logic [0:3] COND_MI = 4'b0100;
    localparam logic [0:3] COND_PL = 4'b0101;
    localparam logic [0:3] COND_VS = 4'b0110;
    localparam logic [0:3] COND_VC = 4'b0111;
    localparam logic [0:3] COND_HI = 4'b1000;
    localparam logic [0:3] COND_LS = 4'b1001;
    localparam logic [0:3] COND_GE = 4'b1010;
    localparam logic [0:3] COND_LT = 4'b1011;
    localparam logic [0:3] COND_GT = 4'b1100;
    localparam logic [0:3] COND_LE = 4'b1101;
    localparam logic [0:3] COND_AL = 4'b1110;
    localparam logic [0:3] COND_NV = 4'b1111;

    // Bit 0 is the MSB, so the register reads {N,Z,C,V} left to right.
    localparam int NZCV_N = 0;
    localparam int NZCV_Z = 1;
    localparam int NZCV_C = 2;
    localparam int NZCV_V = 3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [0:31] result;
        logic [0:3]  rd;
        logic        we;
    } retire_entry_t;

    function automatic logic is_arith(input logic [0:3] op);
        return (op >= OP_ADD) && (op <= OP_SBC);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition evaluator; pure combinational, shared with the branch unit.
module cond_eval
    import alu_pkg::*;
(
    input  logic [0:3] cond,
    input  logic [0:3] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_retire.sv
// Retires ALU results: holds NZCV, evaluates conditions, 2-entry writeback queue.
// Define ALU_CARRY_CHAIN_EN to feed the stored carry back to the ALU carry-in.
module alu_flag_retire
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:3]  in_op,
    input  logic [0:3]  in_cond,
    input  logic        in_s,
    input  logic [0:3]  in_rd,
    input  logic [0:31] alu_y,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_co,
    output logic        alu_ci,
    output logic [0:3]  nzcv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] out_result,
    output logic [0:3]  out_rd,
    output logic        out_we
);

    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          pass;
    logic          push;
    logic          pop;
    retire_entry_t entry_q [DEPTH];
    retire_entry_t head;

    // Conditions see the registered flags, never this cycle's ALU flags.
    cond_eval u_cond_eval (
        .cond (in_cond),
        .nzcv (nzcv),
        .pass (pass)
    );

    assign in_ready  = (count != ST_FULL);
    assign out_valid = (count != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = entry_q[rd_ptr];

    assign out_result = out_valid ? head.result : '0;
    assign out_rd     = out_valid ? head.rd     : '0;
    assign out_we     = out_valid ? head.we     : 1'b0;

`ifdef ALU_CARRY_CHAIN_EN
    assign alu_ci = nzcv[NZCV_C];
`else
    assign alu_ci = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv <= '0;
        end else if (push && pass && in_s) begin
            nzcv[NZCV_N] <= alu_n;
            nzcv[NZCV_Z] <= alu_z;
            if (is_arith(in_op)) begin
                nzcv[NZCV_C] <= alu_co;
                nzcv[NZCV_V] <= alu_v;
            end
        end
    end

    // Failed-condition ops are still queued so writeback order is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
        end else if (push) begin
            entry_q[wr_ptr] <= '{result: alu_y, rd: in_rd, we: pass};
            wr_ptr          <= ~wr_ptr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            count  <= ST_EMPTY;
        end else begin
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_retire.sv
// Scoreboard bench for alu_flag_retire: directed plan cases then random traffic
// checked against a flag/condition reference model.
module tb_alu_flag_retire;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:3]  in_op;
    logic [0:3]  in_cond;
    logic        in_s;
    logic [0:3]  in_rd;
    logic [0:31] alu_y;
    logic        alu_n, alu_z, alu_v, alu_co;
    logic        alu_ci;
    logic [0:3]  nzcv;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] out_result;
    logic [0:3]  out_rd;
    logic        out_we;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mN = 0, mZ = 0, mC = 0, mV = 0;

    alu_flag_retire dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_cond    (in_cond),
        .in_s       (in_s),
        .in_rd      (in_rd),
        .alu_y      (alu_y),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_co     (alu_co),
        .alu_ci     (alu_ci),
        .nzcv       (nzcv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we)
    );

    always #5 clk = ~clk;

    function automatic bit condHolds(int code);
        case (code)
            0:  return mZ;
            1:  return !mZ;
            2:  return mC;
            3:  return !mC;
            4:  return mN;
            5:  return !mN;
            6:  return mV;
            7:  return !mV;
            8:  return mC && !mZ;
            9:  return !mC || mZ;
            10: return mN == mV;
            11: return mN != mV;
            12: return !mZ && (mN == mV);
            13: return mZ || (mN != mV);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] modelFlags();
        return {mN, mZ, mC, mV};
    endfunction

    function automatic bit modelCarryIn();
`ifdef ALU_CARRY_CHAIN_EN
        return mC;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of traffic; the model is updated at the edge where the accept lands.
    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [3:0] cond,
                                 input bit s, input logic [3:0] rd, input logic [31:0] y,
                                 input bit n, input bit z, input bit vf, input bit co,
                                 input bit ordy);
        bit take;
        bit ok;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_cond   = cond;
        in_s      = s;
        in_rd     = rd;
        alu_y     = y;
        alu_n     = n;
        alu_z     = z;
        alu_v     = vf;
        alu_co    = co;
        out_ready = ordy;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, sbq.size() != 2});
        take = v && (sbq.size() < 2);
        @(posedge clk);
        if (take) begin
            ok = condHolds(int'(cond));
            sbq.push_back('{y: y, rd: rd, we: ok});
            if (ok && s) begin
                mN = n;
                mZ = z;
                if (op >= 4'd7 && op <= 4'd10) begin
                    mC = co;
                    mV = vf;
                end
            end
        end
    endtask

    // Monitor: compares the presented head and flags every cycle, popping on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
                if (sbq.size() != 0) begin
                    e = sbq[0];
                    checkOutput("out_result", out_result, e.y);
                    checkOutput("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
                    checkOutput("out_we", {31'd0, out_we}, {31'd0, e.we});
                    if (out_ready) void'(sbq.pop_front());
                end else begin
                    checkOutput("idle_result", out_result, 32'd0);
                    checkOutput("idle_we", {31'd0, out_we}, 32'd0);
                end
                checkOutput("nzcv", {28'd0, nzcv}, {28'd0, modelFlags()});
                checkOutput("alu_ci", {31'd0, alu_ci}, {31'd0, modelCarryIn()});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_cond   = '0;
        in_s      = 1'b0;
        in_rd     = '0;
        alu_y     = '0;
        alu_n     = 1'b0;
        alu_z     = 1'b0;
        alu_v     = 1'b0;
        alu_co    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_nzcv", {28'd0, nzcv}, 32'd0);
        #1 reset = 1'b0;

        applyStimulus(1, 4'b0111, 4'b1110, 1, 4'd1, 32'hEFFFFFFF, 1, 0, 1, 0, 1);
        applyStimulus(1, 4'b1000, 4'b0110, 1, 4'd2, 32'h00000000, 0, 1, 0, 0, 1);
        applyStimulus(1, 4'b1000, 4'b0111, 1, 4'd3, 32'h00000000, 0, 1, 0, 0, 1);
        applyStimulus(1, 4'b1000, 4'b1110, 1, 4'd4, 32'h12345678, 0, 0, 1, 1, 1);
        applyStimulus(1, 4'b0011, 4'b1110, 1, 4'd5, 32'h80000000, 1, 0, 0, 0, 1);
        applyStimulus(0, 4'b0000, 4'b0000, 0, 4'd0, 32'h0, 0, 0, 0, 0, 1);

        applyStimulus(1, 4'b0000, 4'b1110, 0, 4'd1, 32'hA1, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'b0000, 4'b1111, 0, 4'd2, 32'hA2, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'b0000, 4'b1110, 0, 4'd3, 32'hA3, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'b0000, 4'b1110, 0, 4'd3, 32'hA3, 0, 0, 0, 0, 1);
        applyStimulus(1, 4'b0000, 4'b1110, 0, 4'd3, 32'hA3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus(1, 4'b1000, 4'b1110, 1, 4'd6, 32'h1, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus(1, 4'b0111, 4'b1110, 1, 4'd7, 32'hB1, 1, 1, 1, 1, 0);
        applyStimulus(1, 4'b0111, 4'b1110, 1, 4'd8, 32'hB2, 1, 1, 1, 1, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_nzcv", {28'd0, nzcv}, 32'd0);
        checkOutput("midrst_result", out_result, 32'd0);
        checkOutput("midrst_rd", {28'd0, out_rd}, 32'd0);
        checkOutput("midrst_we", {31'd0, out_we}, 32'd0);
        checkOutput("midrst_alu_ci", {31'd0, alu_ci}, 32'd0);
        sbq.delete();
        mN = 0; mZ = 0; mC = 0; mV = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        applyStimulus(1, 4'b0111, 4'b0000, 1, 4'd9, 32'hC0FFEE, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                          1'($urandom), 4'($urandom), $urandom,
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("drain_empty", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
